// File: rtl/cdc_in_packetizer.sv
// -----------------------------------------------------------------------------
// cdc_in_packetizer
//
// Byte FIFO plus packetizer sitting directly in front of the usb_cdc IN
// (device->host) channel. Application bytes enter on a valid/ready port.
// They are released towards usb_cdc in bursts of up to PKT_SIZE bytes, so the
// bulk endpoint sends full-size packets whenever enough data is buffered.
// A partial packet is released after FLUSH_TIMEOUT idle cycles, or straight
// away on a flush_i pulse.
//
// Parameters
//   DEPTH          FIFO entries (power of 2, >= PKT_SIZE)
//   PKT_SIZE       burst length, equal to the usb_cdc bulk IN max packet size
//   FLUSH_TIMEOUT  idle cycles before a partial packet is released (>= 1)
//   DROP_ON_FULL   0: stall the writer when full
//                  1: wr_ready_o is always 1 and bytes are dropped when full
//
// Ports
//   clk_i       in   clock, same domain as usb_cdc
//   rst_i       in   asynchronous reset, active high
//   wr_data_i   in   application byte
//   wr_valid_i  in   application byte valid
//   wr_ready_o  out  FIFO can accept wr_data_i
//   flush_i     in   single-cycle pulse: release buffered bytes now
//   in_data_o   out  byte to usb_cdc in_data_i (first-word fall-through)
//   in_valid_o  out  to usb_cdc in_valid_i
//   in_ready_i  in   from usb_cdc in_ready_o
//   level_o     out  bytes currently stored (0..DEPTH)
//   overflow_o  out  sticky: a byte was dropped (DROP_ON_FULL=1 only)
//   clr_ovf_i   in   clears overflow_o
// -----------------------------------------------------------------------------
module cdc_in_packetizer #(
    parameter int DEPTH         = 16,
    parameter int PKT_SIZE      = 8,
    parameter int FLUSH_TIMEOUT = 1200,
    parameter bit DROP_ON_FULL  = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [7:0]                 wr_data_i,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic                       flush_i,
    output logic [7:0]                 in_data_o,
    output logic                       in_valid_o,
    input  logic                       in_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    input  logic                       clr_ovf_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(PKT_SIZE) + 1;
    localparam int TW = $clog2(FLUSH_TIMEOUT + 1);

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_PKT  = LW'(PKT_SIZE);
    localparam logic [BW-1:0] BST_PKT  = BW'(PKT_SIZE);
    localparam logic [TW-1:0] TMR_MAX  = TW'(FLUSH_TIMEOUT);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_DRAIN   = 1'b1
    } state_t;

    // Storage and bookkeeping registers
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [TW-1:0] r_timer;
    logic [BW-1:0] r_burst;
    logic          r_flush_pend;
    logic          r_overflow;
    state_t        r_state;

    // Combinational helpers
    state_t        w_state_nxt;
    logic          w_drain_go;
    logic          w_not_full;
    logic          w_not_empty;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_drop;
    logic          w_release;
    logic [BW-1:0] w_burst_init;

    assign w_not_full  = (r_level < LVL_FULL);
    assign w_not_empty = (r_level != {LW{1'b0}});

    // In drop mode the writer is never stalled; the full check below still
    // keeps the byte out of the array.
    assign wr_ready_o = DROP_ON_FULL ? 1'b1 : w_not_full;
    assign w_wr_en    = wr_valid_i & wr_ready_o & w_not_full;
    assign w_drop     = DROP_ON_FULL & wr_valid_i & ~w_not_full;

    // A DRAIN state always has at least r_burst (>=1) bytes stored, so the
    // handshake alone qualifies a read.
    assign in_valid_o = (r_state == S_DRAIN);
    assign w_rd_en    = in_valid_o & in_ready_i;
    assign in_data_o  = r_mem[r_rd_ptr];

    // A release needs data plus one trigger: a full packet, an expired idle
    // timer, or a flush (fresh pulse or one left pending from DRAIN).
    assign w_release = w_not_empty &
                       ((r_level >= LVL_PKT) | (r_timer == TMR_MAX) |
                        flush_i | r_flush_pend);

    // The burst is sized from the level seen at the COLLECT->DRAIN edge, so a
    // write landing on that same edge waits for the next burst.
    assign w_burst_init = (r_level >= LVL_PKT) ? BST_PKT : BW'(r_level);

    assign level_o    = r_level;
    assign overflow_o = r_overflow;

    // Next-state logic for the COLLECT/DRAIN packetizer
    always_comb begin
        w_state_nxt = r_state;
        w_drain_go  = 1'b0;
        case (r_state)
            S_COLLECT: begin
                if (w_release) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_go  = 1'b1;
                end else begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_DRAIN: begin
                if (w_rd_en && (r_burst == BW'(1))) begin
                    w_state_nxt = S_COLLECT;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            default: begin
                w_state_nxt = S_COLLECT;
            end
        endcase
    end

    // Packetizer state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Byte array; no reset, contents are invalidated by the pointers
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    // Write and read pointers, wrapping naturally at DEPTH (power of 2)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Fill level; a simultaneous write and read cancel out
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_level <= {LW{1'b0}};
        end else begin
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Idle timer, only counts in COLLECT while data sits unwritten-to
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timer <= {TW{1'b0}};
        end else if ((r_state == S_DRAIN) || w_wr_en || !w_not_empty) begin
            r_timer <= {TW{1'b0}};
        end else if (r_timer != TMR_MAX) begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // Burst counter: loaded on DRAIN entry, decremented per accepted read
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_burst <= {BW{1'b0}};
        end else if (w_drain_go) begin
            r_burst <= w_burst_init;
        end else if (w_rd_en) begin
            r_burst <= r_burst - BW'(1);
        end
    end

    // Flush requested during DRAIN is remembered for the next COLLECT. In
    // COLLECT it is either consumed by the release it triggers or, with an
    // empty FIFO, simply discarded; both cases clear it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_flush_pend <= 1'b0;
        end else if (r_state == S_DRAIN) begin
            if (flush_i) begin
                r_flush_pend <= 1'b1;
            end
        end else begin
            r_flush_pend <= 1'b0;
        end
    end

    // Sticky overflow flag; a new drop wins over a clear in the same cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf_i) begin
            r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdc_in_packetizer.sv
// -----------------------------------------------------------------------------
// Directed bench for cdc_in_packetizer. Instance u_stall uses the stalling
// writer (DROP_ON_FULL=0), instance u_drop uses drop-on-full. Outputs are
// sampled and inputs driven 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_cdc_in_packetizer;

    localparam int FT = 1200;

    logic       clk;
    logic       rst;

    logic [7:0] wr_data0,  wr_data1;
    logic       wr_valid0, wr_valid1;
    logic       wr_ready0, wr_ready1;
    logic       flush0,    flush1;
    logic [7:0] in_data0,  in_data1;
    logic       in_valid0, in_valid1;
    logic       in_ready0, in_ready1;
    logic [4:0] level0,    level1;
    logic       ovf0,      ovf1;
    logic       clr_ovf0,  clr_ovf1;

    int n_checks = 0;
    int n_errors = 0;

    cdc_in_packetizer #(
        .DEPTH(16), .PKT_SIZE(8), .FLUSH_TIMEOUT(FT), .DROP_ON_FULL(1'b0)
    ) u_stall (
        .clk_i(clk), .rst_i(rst),
        .wr_data_i(wr_data0), .wr_valid_i(wr_valid0), .wr_ready_o(wr_ready0),
        .flush_i(flush0),
        .in_data_o(in_data0), .in_valid_o(in_valid0), .in_ready_i(in_ready0),
        .level_o(level0), .overflow_o(ovf0), .clr_ovf_i(clr_ovf0)
    );

    cdc_in_packetizer #(
        .DEPTH(16), .PKT_SIZE(8), .FLUSH_TIMEOUT(FT), .DROP_ON_FULL(1'b1)
    ) u_drop (
        .clk_i(clk), .rst_i(rst),
        .wr_data_i(wr_data1), .wr_valid_i(wr_valid1), .wr_ready_o(wr_ready1),
        .flush_i(flush1),
        .in_data_o(in_data1), .in_valid_o(in_valid1), .in_ready_i(in_ready1),
        .level_o(level1), .overflow_o(ovf1), .clr_ovf_i(clr_ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drain count bytes from u_stall expecting start, start+1, ...
    task automatic drain0(input string tag, input int count, input logic [7:0] start,
                          input int budget);
        logic [7:0] exp_b;
        exp_b     = start;
        in_ready0 = 1'b1;
        for (int k = 0; k < count; k++) begin
            int t;
            t = 0;
            while (!in_valid0 && t < budget) begin
                step();
                t++;
            end
            chk({tag, "_valid"}, 32'(in_valid0), 32'd1);
            chk({tag, "_data"}, 32'(in_data0), 32'(exp_b));
            exp_b = exp_b + 8'd1;
            step();
        end
    endtask

    task automatic write0(input int count, input logic [7:0] start);
        logic [7:0] b;
        b = start;
        for (int k = 0; k < count; k++) begin
            wr_valid0 = 1'b1;
            wr_data0  = b;
            b         = b + 8'd1;
            step();
        end
        wr_valid0 = 1'b0;
    endtask

    initial begin
        int acc;
        int idle;
        logic [7:0] b;

        rst       = 1'b1;
        wr_data0  = 8'h00; wr_valid0 = 1'b0; flush0 = 1'b0; in_ready0 = 1'b0; clr_ovf0 = 1'b0;
        wr_data1  = 8'h00; wr_valid1 = 1'b0; flush1 = 1'b0; in_ready1 = 1'b0; clr_ovf1 = 1'b0;
        step();
        step();

        // Reset values
        chk("rst_valid0",  32'(in_valid0), 32'd0);
        chk("rst_level0",  32'(level0),    32'd0);
        chk("rst_ready0",  32'(wr_ready0), 32'd1);
        chk("rst_ovf1",    32'(ovf1),      32'd0);
        chk("rst_ready1",  32'(wr_ready1), 32'd1);
        rst = 1'b0;
        step();

        // 1: full packet 0x00..0x07 with ready high
        in_ready0 = 1'b1;
        write0(8, 8'h00);
        chk("t1_level8",  32'(level0),    32'd8);
        chk("t1_novalid", 32'(in_valid0), 32'd0);
        drain0("t1", 8, 8'h00, 4);
        chk("t1_valid_after", 32'(in_valid0), 32'd0);
        chk("t1_level_after", 32'(level0),    32'd0);

        // 2: partial packet released by the idle timer
        write0(3, 8'hA1);
        chk("t2_level3", 32'(level0), 32'd3);
        idle = 0;
        while (!in_valid0 && idle < FT + 100) begin
            step();
            idle++;
        end
        // timer is 0 after the write edge and reaches FT after FT more edges;
        // DRAIN follows one edge later
        chk("t2_idle_cycles", 32'(idle), 32'(FT + 1));
        drain0("t2", 3, 8'hA1, 2);
        chk("t2_valid_after", 32'(in_valid0), 32'd0);
        chk("t2_level_after", 32'(level0),    32'd0);

        // 4: drop-on-full instance, 18 writes with ready low
        in_ready1 = 1'b0;
        b = 8'h00;
        for (int k = 0; k < 18; k++) begin
            wr_valid1 = 1'b1;
            wr_data1  = b;
            b         = b + 8'd1;
            step();
        end
        wr_valid1 = 1'b0;
        chk("t4_level16", 32'(level1),    32'd16);
        chk("t4_ovf",     32'(ovf1),      32'd1);
        chk("t4_ready",   32'(wr_ready1), 32'd1);
        step();
        chk("t4_ovf_sticky", 32'(ovf1), 32'd1);
        clr_ovf1 = 1'b1;
        step();
        clr_ovf1 = 1'b0;
        chk("t4_ovf_clr", 32'(ovf1), 32'd0);
        in_ready1 = 1'b1;
        b = 8'h00;
        for (int k = 0; k < 16; k++) begin
            int t;
            t = 0;
            while (!in_valid1 && t < 4) begin
                step();
                t++;
            end
            chk("t4_valid", 32'(in_valid1), 32'd1);
            chk("t4_data",  32'(in_data1),  32'(b));
            b = b + 8'd1;
            step();
        end
        chk("t4_level_after", 32'(level1),    32'd0);
        chk("t4_valid_after", 32'(in_valid1), 32'd0);

        // 3: stalling instance, 20 offered bytes with ready low
        in_ready0 = 1'b0;
        acc = 0;
        b   = 8'h00;
        for (int k = 0; k < 20; k++) begin
            wr_valid0 = 1'b1;
            wr_data0  = b;
            b         = b + 8'd1;
            if (wr_ready0) acc++;
            step();
        end
        wr_valid0 = 1'b0;
        chk("t3_accepted", 32'(acc),       32'd16);
        chk("t3_level16",  32'(level0),    32'd16);
        chk("t3_ready0",   32'(wr_ready0), 32'd0);
        chk("t3_hold_valid", 32'(in_valid0), 32'd1);
        chk("t3_hold_data",  32'(in_data0),  32'h00);
        step();
        step();
        chk("t3_hold_valid2", 32'(in_valid0), 32'd1);
        chk("t3_hold_data2",  32'(in_data0),  32'h00);
        chk("t3_hold_level",  32'(level0),    32'd16);
        drain0("t3a", 8, 8'h00, 1);
        chk("t3_gap_valid", 32'(in_valid0), 32'd0);
        chk("t3_gap_level", 32'(level0),    32'd8);
        drain0("t3b", 8, 8'h08, 3);
        chk("t3_level_after", 32'(level0),    32'd0);
        chk("t3_valid_after", 32'(in_valid0), 32'd0);

        // 5: explicit flush of a partial packet, then flush while empty
        write0(5, 8'h30);
        chk("t5_level5", 32'(level0), 32'd5);
        flush0 = 1'b1;
        step();
        flush0 = 1'b0;
        drain0("t5", 5, 8'h30, 2);
        chk("t5_valid_after", 32'(in_valid0), 32'd0);
        chk("t5_level_after", 32'(level0),    32'd0);
        flush0 = 1'b1;
        step();
        flush0 = 1'b0;
        idle = 0;
        for (int k = 0; k < 4; k++) begin
            if (in_valid0) idle++;
            step();
        end
        chk("t5_empty_flush_valid", 32'(idle), 32'd0);

        // 6: asynchronous reset in the middle of DRAIN
        in_ready0 = 1'b0;
        write0(8, 8'h10);
        step();
        chk("t6_drain_valid", 32'(in_valid0), 32'd1);
        in_ready0 = 1'b1;
        step();
        chk("t6_second_byte", 32'(in_data0), 32'h11);
        in_ready0 = 1'b0;
        step();
        in_ready0 = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(in_valid0), 32'd0);
        chk("t6_rst_level", 32'(level0),    32'd0);
        step();
        rst = 1'b0;
        step();
        chk("t6_post_valid", 32'(in_valid0), 32'd0);
        write0(8, 8'h50);
        drain0("t6", 8, 8'h50, 4);
        chk("t6_level_after", 32'(level0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
